mul8_seq: RTL and testbench



---
 rtl/mul8_pkg.sv | 17 +
 rtl/csa8.sv | 21 ++
 rtl/mul8_seq.sv | 100 ++++++++++
 tb/tb_mul8_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8x8 shift-add multiplier.
package mul8_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int STEPS  = 8;
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/csa8.sv
// 8-bit carry-select adder: ripple low nibble, precomputed high nibble for both carries.
module csa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/mul8_seq.sv
// Sequential unsigned 8x8->16 multiplier, one partial-product add per cycle on csa8,
// with valid/ready handshakes on operand and result sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// BUSY  | eight shift-add steps in progress
// DONE  | product presented, waiting for out_ready
module mul8_seq
    import mul8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product
);

    state_e              state_q;
    logic [OP_W-1:0]     mcand_q;
    logic [OP_W-1:0]     acc_hi_q;
    logic [OP_W-1:0]     acc_lo_q;
    logic [CNT_W-1:0]    count_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [PROD_W-1:0]   product_q;

    logic [OP_W-1:0]     addend;
    logic [OP_W-1:0]     sum;
    logic                cout;
    logic [PROD_W-1:0]   acc_d;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    csa8 u_csa8 (
        .a    (acc_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Adder carry enters at the MSB so the 17-bit partial sum is never truncated.
    assign acc_d = {cout, sum, acc_lo_q[OP_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= a;
                        acc_lo_q   <= b;
                        acc_hi_q   <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    {acc_hi_q, acc_lo_q} <= acc_d;
                    count_q              <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: transaction-level model plus directed vectors.
module tb_mul8_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Transaction model: one op in flight, result visible 8 edges after the accept edge.
    bit          pending = 1'b0;
    int          since   = 0;
    logic [15:0] exp_prod = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  = 1'b0;
            since    = 0;
            exp_prod = 16'h0000;
        end else if (pending) begin
            if (since >= 8 && out_ready) pending = 1'b0;
            else                         since++;
        end else if (in_valid) begin
            pending  = 1'b1;
            since    = 0;
            exp_prod = 16'(a) * 16'(b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            check("mon_in_ready", 32'(in_ready), 32'(!pending));
            check("mon_out_valid", 32'(out_valid), 32'(pending && since >= 8));
            if (pending && since >= 8)
                check("mon_product", 32'(product), 32'(exp_prod));
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] lit,
                         input int hold, input bit noise);
        int lat;
        @(negedge clk);
        check("pre_in_ready", 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        if (noise) begin
            in_valid = 1'b1;
            a        = 8'h11;
            b        = 8'h11;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 4) in_valid = 1'b0;
        end
        check("latency_edges", 32'(lat), 32'd8);
        check("product", 32'(product), 32'(lit));
        check("out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_product", 32'(product), 32'(lit));
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'h0);
        rst_n = 1'b1;

        do_op(8'd13, 8'd11, 16'h008F, 0, 1'b0);
        check("model_pin_13x11", 32'(exp_prod), 32'h008F);
        do_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
        check("model_pin_ffxff", 32'(exp_prod), 32'hFE01);
        do_op(8'h00, 8'h5A, 16'h0000, 0, 1'b0);
        do_op(8'h5A, 8'h00, 16'h0000, 0, 1'b0);
        do_op(8'h80, 8'h02, 16'h0100, 5, 1'b1);

        // Asynchronous reset in the middle of BUSY, between clock edges.
        @(negedge clk);
        a        = 8'hC3;
        b        = 8'h7E;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_product", 32'(product), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'd3, 8'd5, 16'h000F, 0, 1'b0);

        do_op(8'd1, 8'd1, 16'h0001, 0, 1'b0);
        do_op(8'd200, 8'd100, 16'h4E20, 0, 1'b0);
        do_op(8'd255, 8'd1, 16'h00FF, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
